// File: rtl/range_gen_pkg.sv
// range_gen_pkg: shared widths, FSM encoding, timing constants and small
// arithmetic helpers for the 2D range generator (range_gen_2d) and its
// sequential square-root engine (isqrt_seq).
package range_gen_pkg;

  localparam int W      = 16;        // coordinate / range width (unsigned)
  localparam int RAD_W  = 2 * W + 2; // radicand width, one guard bit above dx^2+dy^2
  localparam int ROOT_W = W + 1;     // raw root width before saturation

  localparam logic [W-1:0] SAT_MAX = '1;

  localparam int CYC_PER_ANCHOR = 18; // 1 SQR cycle + ROOT_W ROOT cycles
  localparam int TOTAL_LAT      = 72; // 4 anchors, accept edge to done edge

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    ROOT = 2'd2
  } state_e;

  // |d| for a W+1-bit signed difference of two unsigned W-bit values; the
  // magnitude always fits back into W bits.
  function automatic logic [W-1:0] abs_diff(input logic signed [W:0] d);
    return W'(d[W] ? -d : d);
  endfunction

  // Clamp a raw root to the W-bit range; the only out-of-range bit is the MSB.
  function automatic logic [W-1:0] sat_root(input logic [ROOT_W-1:0] r);
    return r[ROOT_W-1] ? SAT_MAX : r[W-1:0];
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// isqrt_seq: restoring bit-serial integer square root, one root bit per
// cycle, MSB first, fixed ROOT_W iterations after a load.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   load   in   capture rad and start a new root (restarts any root in flight)
//   rad    in   RAD_W-bit radicand
//   root   out  ROOT_W-bit root; equals floor(sqrt(rad)) during the rdy cycle
//   rdy    out  high in the cycle whose closing edge retires the last bit
//
// root is the combinational next value of the partial root, so the owner
// can capture the finished result on the same edge that computes the LSB.
module isqrt_seq
  import range_gen_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [RAD_W-1:0]  rad,
  output logic [ROOT_W-1:0] root,
  output logic              rdy
);

  localparam int REM_W = ROOT_W + 1;       // remainder <= 2*root < 2^(ROOT_W+1)
  localparam logic [4:0] LAST = 5'(ROOT_W - 1);

  logic [RAD_W-1:0]  rad_q, rad_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              act_q, act_d;

  logic [REM_W+1:0]  rem_sh;  // remainder with the next two radicand bits appended
  logic [REM_W+1:0]  trial;   // 4*root + 1

  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    rem_sh = {rem_q, rad_q[RAD_W-1 -: 2]};
    trial  = {1'b0, root_q, 2'b01};
    if (load) begin
      rad_d  = rad;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = '0;
      act_d  = 1'b1;
    end else if (act_q) begin
      rad_d = {rad_q[RAD_W-3:0], 2'b00};
      if (rem_sh >= trial) begin
        rem_d  = REM_W'(rem_sh - trial);
        root_d = {root_q[ROOT_W-2:0], 1'b1};
      end else begin
        rem_d  = REM_W'(rem_sh);
        root_d = {root_q[ROOT_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == LAST) begin
        act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      act_q  <= 1'b0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
    end
  end

  assign root = root_d;
  assign rdy  = act_q && (cnt_q == LAST);

endmodule

// File: rtl/range_gen_2d.sv
// range_gen_2d: forward model of the 2D UWB localiser. Given a tag position
// and four anchors it produces r_k = min(floor(sqrt(dx^2+dy^2)), 2^W-1) per
// anchor, with a fixed 72-cycle latency from the accept edge to done.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset (aborts any operation)
//   start         in   request, sampled only while idle (busy=0)
//   x_tag, y_tag  in   tag coordinates, W-bit unsigned
//   x0..x3,y0..y3 in   anchor coordinates, W-bit unsigned
//   busy          out  high from the accept edge until the done edge
//   done          out  one-cycle pulse when r0..r3/ovf carry a new result
//   r0..r3        out  saturated ranges, updated only on the done edge
//   ovf           out  bit k set when r_k saturated
//
// Sequence per anchor k: one SQR cycle builds dx^2+dy^2 and loads the root
// engine, then ROOT_W ROOT cycles. Results collect in shadow registers so the
// visible outputs only move on the done edge.
module range_gen_2d
  import range_gen_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] x_tag,
  input  logic [W-1:0] y_tag,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  input  logic [W-1:0] y0,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] y2,
  input  logic [W-1:0] y3,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] r0,
  output logic [W-1:0] r1,
  output logic [W-1:0] r2,
  output logic [W-1:0] r3,
  output logic [3:0]   ovf
);

  state_e       state_q, state_d;
  logic [1:0]   k_q, k_d;
  logic [W-1:0] tx_q, tx_d, ty_q, ty_d;
  logic [W-1:0] ax_q [4];
  logic [W-1:0] ax_d [4];
  logic [W-1:0] ay_q [4];
  logic [W-1:0] ay_d [4];
  logic [W-1:0] sh_q [4];
  logic [W-1:0] sh_d [4];
  logic [3:0]   sovf_q, sovf_d;
  logic [W-1:0] r_q [4];
  logic [W-1:0] r_d [4];
  logic [3:0]   ovf_q, ovf_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [W-1:0]      ax_in [4];
  logic [W-1:0]      ay_in [4];
  logic signed [W:0] ddx, ddy;
  logic [W-1:0]      dx, dy;
  logic [RAD_W-1:0]  rad;
  logic              load;
  logic              rdy;
  logic [ROOT_W-1:0] root;

  assign ax_in[0] = x0;
  assign ax_in[1] = x1;
  assign ax_in[2] = x2;
  assign ax_in[3] = x3;
  assign ay_in[0] = y0;
  assign ay_in[1] = y1;
  assign ay_in[2] = y2;
  assign ay_in[3] = y3;

  // Squared distance to the current anchor, exact in RAD_W bits.
  always_comb begin
    ddx = $signed({1'b0, tx_q}) - $signed({1'b0, ax_q[k_q]});
    ddy = $signed({1'b0, ty_q}) - $signed({1'b0, ay_q[k_q]});
    dx  = abs_diff(ddx);
    dy  = abs_diff(ddy);
    rad = RAD_W'(dx) * RAD_W'(dx) + RAD_W'(dy) * RAD_W'(dy);
  end

  assign load = (state_q == SQR);

  isqrt_seq u_isqrt (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .rad   (rad),
    .root  (root),
    .rdy   (rdy)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    sh_d    = sh_q;
    sovf_d  = sovf_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Also reached in the done cycle, which gives back-to-back accepts.
        if (start) begin
          tx_d    = x_tag;
          ty_d    = y_tag;
          ax_d    = ax_in;
          ay_d    = ay_in;
          k_d     = 2'd0;
          busy_d  = 1'b1;
          state_d = SQR;
        end
      end
      SQR: begin
        state_d = ROOT;
      end
      ROOT: begin
        if (rdy) begin
          sh_d[k_q]   = sat_root(root);
          sovf_d[k_q] = root[ROOT_W-1];
          if (k_q == 2'd3) begin
            // Publish all four ranges at once, including the one just finished.
            r_d     = sh_d;
            ovf_d   = sovf_d;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = SQR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      ax_q    <= '{default: '0};
      ay_q    <= '{default: '0};
      sh_q    <= '{default: '0};
      sovf_q  <= '0;
      r_q     <= '{default: '0};
      ovf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      sh_q    <= sh_d;
      sovf_q  <= sovf_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign r0   = r_q[0];
  assign r1   = r_q[1];
  assign r2   = r_q[2];
  assign r3   = r_q[3];
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_range_gen_2d.sv
// Testbench for range_gen_2d: a transaction-level reference model (exact
// integer sqrt of the squared distance, saturated) predicts busy/done and the
// outputs every cycle; directed cases pin the model with hand-computed values.
module tb_range_gen_2d;

  localparam int W   = 16;
  localparam int LAT = 72;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] x_tag = '0;
  logic [W-1:0] y_tag = '0;
  logic [W-1:0] ax [4];
  logic [W-1:0] ay [4];
  logic         busy, done;
  logic [W-1:0] r0, r1, r2, r3;
  logic [3:0]   ovf;

  int n_checks = 0;
  int n_errors = 0;

  range_gen_2d dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x_tag (x_tag),
    .y_tag (y_tag),
    .x0    (ax[0]),
    .x1    (ax[1]),
    .x2    (ax[2]),
    .x3    (ax[3]),
    .y0    (ay[0]),
    .y1    (ay[1]),
    .y2    (ay[2]),
    .y3    (ay[3]),
    .busy  (busy),
    .done  (done),
    .r0    (r0),
    .r1    (r1),
    .r2    (r2),
    .r3    (r3),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint isqrt_floor(input longint v);
    longint lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 20;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  function automatic longint range_of(input longint tx, input longint ty,
                                      input longint px, input longint py);
    longint dx, dy;
    dx = (tx > px) ? tx - px : px - tx;
    dy = (ty > py) ? ty - py : py - ty;
    return isqrt_floor(dx * dx + dy * dy);
  endfunction

  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_cnt  = 0;
  logic [W-1:0] m_r [4];
  logic [W-1:0] p_r [4];
  logic [3:0]   m_ovf = '0;
  logic [3:0]   p_ovf = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
      m_ovf  = '0;
      for (int i = 0; i < 4; i++) m_r[i] = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == LAT) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_r    = p_r;
          m_ovf  = p_ovf;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        for (int i = 0; i < 4; i++) begin
          longint rv;
          rv = range_of(x_tag, y_tag, ax[i], ay[i]);
          p_ovf[i] = (rv > 65535);
          p_r[i]   = (rv > 65535) ? 16'hFFFF : W'(rv);
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("r0", r0, m_r[0]);
    chk("r1", r1, m_r[1]);
    chk("r2", r2, m_r[2]);
    chk("r3", r3, m_r[3]);
    chk("ovf", ovf, m_ovf);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_anchors(input int a0x, input int a0y, input int a1x, input int a1y,
                             input int a2x, input int a2y, input int a3x, input int a3y);
    ax[0] = W'(a0x); ay[0] = W'(a0y);
    ax[1] = W'(a1x); ay[1] = W'(a1y);
    ax[2] = W'(a2x); ay[2] = W'(a2y);
    ax[3] = W'(a3x); ay[3] = W'(a3y);
  endtask

  // One operation; optionally pulses start for one cycle at pulse_at edges
  // after the accept edge. Inputs are scrambled after the accept edge.
  task automatic run_op(input int tx, input int ty, input int pulse_at, output int lat);
    bit got;
    @(negedge clk);
    x_tag = W'(tx);
    y_tag = W'(ty);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x_tag = W'($urandom);
    y_tag = W'($urandom);
    for (int i = 0; i < 4; i++) begin
      ax[i] = W'($urandom);
      ay[i] = W'($urandom);
    end
    lat = 0;
    got = 0;
    while (!got && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      start = (lat == pulse_at);
      @(negedge clk);
      if (done) got = 1;
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    chk("latency", lat, LAT);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dones;
    set_anchors(0, 0, 2000, 0, 0, 2000, 2000, 2000);
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_r0", r0, 0);
    chk("reset_ovf", ovf, 0);
    reset = 1'b1;
    @(negedge clk);

    // Square of anchors, tag at the origin.
    run_op(0, 0, 0, lat);
    chk("sq_r0", r0, 0);
    chk("sq_r1", r1, 2000);
    chk("sq_r2", r2, 2000);
    chk("sq_r3", r3, 2828);
    chk("sq_ovf", ovf, 0);

    set_anchors(0, 0, 2000, 0, 0, 2000, 2000, 2000);
    run_op(1000, 1000, 0, lat);
    chk("ctr_r0", r0, 1414);
    chk("ctr_r1", r1, 1414);
    chk("ctr_r2", r2, 1414);
    chk("ctr_r3", r3, 1414);
    chk("ctr_ovf", ovf, 0);

    // r0: 3000,500 -> 3041; r1: 1000,500 -> 1118; r2: 3000,1500 -> 3354; r3: 1000,1500 -> 1802.
    set_anchors(0, 0, 2000, 0, 0, 2000, 2000, 2000);
    run_op(3000, 500, 0, lat);
    chk("out_r0", r0, 3041);
    chk("out_r1", r1, 1118);
    chk("out_r2", r2, 3354);
    chk("out_r3", r3, 1802);

    // Saturation boundary.
    set_anchors(0, 0, 0, 0, 0, 0, 0, 0);
    run_op(65535, 65535, 0, lat);
    chk("sat_r0", r0, 65535);
    chk("sat_r3", r3, 65535);
    chk("sat_ovf", ovf, 4'b1111);
    set_anchors(0, 0, 0, 0, 0, 0, 0, 0);
    run_op(46340, 46340, 0, lat);
    chk("edge_r1", r1, 65534);
    chk("edge_ovf", ovf, 0);

    // Tag on an anchor gives zero range.
    set_anchors(123, 456, 123, 456, 7, 9, 60000, 60000);
    run_op(123, 456, 0, lat);
    chk("same_r0", r0, 0);
    chk("same_r1", r1, 0);

    // Random positions, including far corners that saturate.
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) begin
        ax[i] = W'($urandom);
        ay[i] = W'($urandom);
      end
      run_op(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 0, lat);
    end

    // Start pulse during busy is ignored.
    set_anchors(0, 0, 2000, 0, 0, 2000, 2000, 2000);
    run_op(1000, 1000, 30, lat);
    chk("busy_pulse_r2", r2, 1414);
    repeat (100) begin
      @(negedge clk);
    end
    chk("busy_pulse_no_op", busy, 0);

    // Start held high: accepts on edge 0 and again in each done cycle.
    @(negedge clk);
    set_anchors(0, 0, 2000, 0, 0, 2000, 2000, 2000);
    x_tag = 16'd500;
    y_tag = 16'd700;
    start = 1'b1;
    dones = 0;
    for (int e = 0; e < 200; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (dones == 0) chk("hold_done1_edge", e, 72);
        else chk("hold_done2_edge", e, 145);
        dones++;
      end
    end
    start = 1'b0;
    chk("hold_done_count", dones, 2);
    wait_idle();

    // Asynchronous reset mid-operation.
    @(negedge clk);
    set_anchors(0, 0, 2000, 0, 0, 2000, 2000, 2000);
    x_tag = 16'd3000;
    y_tag = 16'd500;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_r0", r0, 0);
    chk("abort_r3", r3, 0);
    chk("abort_ovf", ovf, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (80) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    set_anchors(0, 0, 2000, 0, 0, 2000, 2000, 2000);
    run_op(0, 0, 0, lat);
    chk("post_abort_r3", r3, 2828);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
